// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
// Arbitrates the control unit's instruction-fetch and data requests onto one
// shared single-port memory that inserts a variable number of wait states.
// A data access always wins over a fetch because it belongs to the older
// instruction. Each access runs IDLE -> BUSY -> DONE -> IDLE. DONE lasts one
// cycle and emits a completion (MFC) pulse to the requester. Read data is
// captured in per-port holding registers.

module mem_access_sequencer #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LAT     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,

    // instruction fetch port (ReadIM)
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic [DW-1:0] if_rdata_o,
    output logic          if_done_o,

    // data port (ReadDM / WriteDM)
    input  logic          dm_rd_i,
    input  logic          dm_wr_i,
    input  logic [AW-1:0] dm_addr_i,
    input  logic [DW-1:0] dm_wdata_i,
    output logic [DW-1:0] dm_rdata_o,
    output logic          dm_done_o,

    // stall level towards the control unit (WMFC)
    output logic          stall_o,

    // shared memory port
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ready_i,

    // sticky error flags, cleared only by rst_i
    output logic          err_conflict_o,
    output logic          err_timeout_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // The timeout counter must be able to hold TIMEOUT itself.
    localparam int TW = $clog2(TIMEOUT + 1);

    // Value loaded into the wait counter when an access is granted.
    localparam logic [3:0] LAT_C = 4'(LAT);

    // The counter holds the number of BUSY cycles already completed. When
    // it equals TIMEOUT-1, the current cycle is the last one allowed.
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]    state_q,    state_d;
    logic [3:0]    wait_q,     wait_d;
    logic [TW-1:0] to_cnt_q,   to_cnt_d;
    logic [AW-1:0] addr_q,     addr_d;
    logic [DW-1:0] wdata_q,    wdata_d;
    logic          is_wr_q,    is_wr_d;
    logic          is_dm_q,    is_dm_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          if_done_q,  if_done_d;
    logic          dm_done_q,  dm_done_d;
    logic          mem_en_q,   mem_en_d;
    logic          mem_we_q,   mem_we_d;
    logic          err_conf_q, err_conf_d;
    logic          err_to_q,   err_to_d;

    // Helper terms for the BUSY state.
    logic          wait_over_s;
    logic          complete_s;
    logic          abort_s;

    // Decode when the current BUSY cycle may finish.
    always_comb begin
        wait_over_s = (wait_q == 4'd0);
        complete_s  = (state_q == ST_BUSY) && wait_over_s && mem_ready_i;
        // A real completion in the last allowed cycle takes precedence
        // over the abort.
        abort_s     = (state_q == ST_BUSY) && !complete_s && (to_cnt_q == TO_LAST);
    end

    // Next-state logic: arbitration in IDLE, wait/timeout tracking in BUSY.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        to_cnt_d   = to_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_wr_d    = is_wr_q;
        is_dm_d    = is_dm_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        err_conf_d = err_conf_q;
        err_to_d   = err_to_q;

        case (state_q)
            ST_IDLE: begin
                if (dm_wr_i) begin
                    // A write wins even when a read is raised at the same
                    // time. That collision is flagged.
                    state_d  = ST_BUSY;
                    addr_d   = dm_addr_i;
                    wdata_d  = dm_wdata_i;
                    is_wr_d  = 1'b1;
                    is_dm_d  = 1'b1;
                    wait_d   = LAT_C;
                    to_cnt_d = '0;
                    if (dm_rd_i) begin
                        err_conf_d = 1'b1;
                    end else begin
                        err_conf_d = err_conf_q;
                    end
                end else if (dm_rd_i) begin
                    state_d  = ST_BUSY;
                    addr_d   = dm_addr_i;
                    wdata_d  = dm_wdata_i;
                    is_wr_d  = 1'b0;
                    is_dm_d  = 1'b1;
                    wait_d   = LAT_C;
                    to_cnt_d = '0;
                end else if (if_req_i) begin
                    state_d  = ST_BUSY;
                    addr_d   = if_addr_i;
                    wdata_d  = '0;
                    is_wr_d  = 1'b0;
                    is_dm_d  = 1'b0;
                    wait_d   = LAT_C;
                    to_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BUSY: begin
                to_cnt_d = to_cnt_q + TW'(1);
                if (wait_over_s) begin
                    wait_d = 4'd0;
                end else begin
                    wait_d = wait_q - 4'd1;
                end

                if (complete_s) begin
                    state_d = ST_DONE;
                    if (is_wr_q) begin
                        if_rdata_d = if_rdata_q;
                    end else if (is_dm_q) begin
                        dm_rdata_d = mem_rdata_i;
                    end else begin
                        if_rdata_d = mem_rdata_i;
                    end
                    if_done_d = !is_dm_q;
                    dm_done_d = is_dm_q;
                end else if (abort_s) begin
                    // Give up. The requester still gets its pulse, and the
                    // read holding registers keep their old contents.
                    state_d   = ST_DONE;
                    err_to_d  = 1'b1;
                    if_done_d = !is_dm_q;
                    dm_done_d = is_dm_q;
                end else begin
                    state_d = ST_BUSY;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Register the memory strobes so they come straight from flops.
        mem_en_d = (state_d == ST_BUSY);
        mem_we_d = (state_d == ST_BUSY) && is_wr_d;
    end

    // FSM state and access counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            wait_q   <= 4'd0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Latched access descriptor, held stable for the whole BUSY phase.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            is_dm_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            is_dm_q <= is_dm_d;
        end
    end

    // Per-port read data holding registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // Completion pulses and memory strobes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
        end else begin
            if_done_q <= if_done_d;
            dm_done_q <= dm_done_d;
            mem_en_q  <= mem_en_d;
            mem_we_q  <= mem_we_d;
        end
    end

    // Sticky error flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_conf_q <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            err_conf_q <= err_conf_d;
            err_to_q   <= err_to_d;
        end
    end

    // Output mapping. The stall term is combinational so that the control
    // unit sees a new request stall in the same cycle it is raised.
    always_comb begin
        if_rdata_o     = if_rdata_q;
        dm_rdata_o     = dm_rdata_q;
        if_done_o      = if_done_q;
        dm_done_o      = dm_done_q;
        mem_en_o       = mem_en_q;
        mem_we_o       = mem_we_q;
        mem_addr_o     = addr_q;
        mem_wdata_o    = wdata_q;
        err_conflict_o = err_conf_q;
        err_timeout_o  = err_to_q;
        stall_o        = (if_req_i | dm_rd_i | dm_wr_i) & ~(if_done_q | dm_done_q);
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer. The reference is written at
// transaction level. Each access is reduced to its grant (priority order),
// a BUSY length of min(LAT+1+extra_wait, TIMEOUT) and a DONE cycle. The
// expected memory-side and control-side outputs are checked every cycle.
module tb_mem_access_sequencer;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int LAT     = 2;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, dm_rd, dm_wr, mem_ready;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata, mem_rdata;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          if_done, dm_done, stall, mem_en, mem_we, err_conflict, err_timeout;

    // model state
    logic [DW-1:0] exp_if_rdata, exp_dm_rdata;
    logic          exp_err_c, exp_err_t;

    // observations of the last transaction, used for literal pins
    int            obs_busy;
    logic          obs_we, obs_done_if, obs_done_dm;

    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_sequencer #(.AW(AW), .DW(DW), .LAT(LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .if_req_i       (if_req),
        .if_addr_i      (if_addr),
        .if_rdata_o     (if_rdata),
        .if_done_o      (if_done),
        .dm_rd_i        (dm_rd),
        .dm_wr_i        (dm_wr),
        .dm_addr_i      (dm_addr),
        .dm_wdata_i     (dm_wdata),
        .dm_rdata_o     (dm_rdata),
        .dm_done_o      (dm_done),
        .stall_o        (stall),
        .mem_en_o       (mem_en),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata),
        .mem_ready_i    (mem_ready),
        .err_conflict_o (err_conflict),
        .err_timeout_o  (err_timeout)
    );

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // single compare point: all DUT outputs against the model
    task automatic check_outs(input logic busy, input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input logic ifd, input logic dmd);
        logic exp_stall;
        exp_stall = (if_req | dm_rd | dm_wr) & ~(ifd | dmd);
        cmp("mem_en", 64'(mem_en), 64'(busy));
        cmp("mem_we", 64'(mem_we), 64'(busy & we));
        if (busy) begin
            cmp("mem_addr", 64'(mem_addr), 64'(a));
            if (we) cmp("mem_wdata", 64'(mem_wdata), 64'(wd));
        end
        cmp("if_done", 64'(if_done), 64'(ifd));
        cmp("dm_done", 64'(dm_done), 64'(dmd));
        cmp("stall", 64'(stall), 64'(exp_stall));
        cmp("if_rdata", 64'(if_rdata), 64'(exp_if_rdata));
        cmp("dm_rdata", 64'(dm_rdata), 64'(exp_dm_rdata));
        cmp("err_conflict", 64'(err_conflict), 64'(exp_err_c));
        cmp("err_timeout", 64'(err_timeout), 64'(exp_err_t));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise the requested signals (joined with any still held), run one access.
    task automatic do_txn(input logic new_if, input logic new_rd, input logic new_wr,
                          input logic [AW-1:0] ia, input logic [AW-1:0] da,
                          input logic [DW-1:0] wd, input int d, input logic drop,
                          input logic fix_rd, input logic [DW-1:0] rdv);
        logic          g_dm, g_wr;
        logic [AW-1:0] g_addr;
        logic [DW-1:0] g_wd, rd;
        int            len;
        logic          tmo;
        if (new_if && !if_req) begin if_req = 1'b1; if_addr = ia; end
        if ((new_rd || new_wr) && !(dm_rd || dm_wr)) begin dm_addr = da; dm_wdata = wd; end
        if (new_rd) dm_rd = 1'b1;
        if (new_wr) dm_wr = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        obs_busy = 0; obs_we = 1'b0; obs_done_if = 1'b0; obs_done_dm = 1'b0;
        check_outs(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        if (!(if_req | dm_rd | dm_wr)) begin
            step();
            return;
        end
        // grant by priority: write, then read, then fetch
        g_dm   = dm_rd | dm_wr;
        g_wr   = dm_wr;
        g_addr = g_dm ? dm_addr : if_addr;
        g_wd   = dm_wdata;
        if (dm_rd && dm_wr) exp_err_c = 1'b1;
        tmo = (LAT + 1 + d) > TIMEOUT;
        len = tmo ? TIMEOUT : LAT + 1 + d;
        step();
        for (int k = 1; k <= len; k++) begin
            check_outs(1'b1, g_wr, g_addr, g_wd, 1'b0, 1'b0);
            if (mem_en) obs_busy++;
            if (mem_we) obs_we = 1'b1;
            if (k == 1 && drop) begin
                if (g_dm) begin dm_rd = 1'b0; dm_wr = 1'b0; end
                else if_req = 1'b0;
            end
            rd        = fix_rd ? rdv : $urandom;
            mem_rdata = rd;
            if (k <= LAT) mem_ready = 1'($urandom_range(0, 1));
            else          mem_ready = (k >= LAT + 1 + d);
            step();
            if (k == len) begin
                if (tmo) exp_err_t = 1'b1;
                else if (!g_wr) begin
                    if (g_dm) exp_dm_rdata = rd;
                    else      exp_if_rdata = rd;
                end
            end
        end
        obs_done_if = if_done;
        obs_done_dm = dm_done;
        check_outs(1'b0, 1'b0, '0, '0, !g_dm, g_dm);
        if (g_dm) begin dm_rd = 1'b0; dm_wr = 1'b0; end
        else if_req = 1'b0;
        mem_ready = 1'b0;
        step();
        check_outs(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rq;
        rst = 1'b1;
        if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0; mem_ready = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        exp_if_rdata = '0; exp_dm_rdata = '0; exp_err_c = 1'b0; exp_err_t = 1'b0;
        #1;
        // reset state
        check_outs(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        cmp("rst_mem_addr", 64'(mem_addr), 64'd0);
        cmp("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        step(); step();
        rst = 1'b0;
        step();

        // fetch at 0x10, ready throughout
        do_txn(1'b1, 1'b0, 1'b0, 32'h10, '0, '0, 0, 1'b0, 1'b1, 32'hDEADBEEF);
        cmp("t1_busy_cycles", 64'(obs_busy), 64'd3);
        cmp("t1_if_done", 64'(obs_done_if), 64'd1);
        cmp("t1_if_rdata", 64'(if_rdata), 64'hDEADBEEF);

        // fetch and write together: write first, then the held fetch
        do_txn(1'b1, 1'b0, 1'b1, 32'h80, 32'h40, 32'h5, 0, 1'b0, 1'b0, '0);
        cmp("t2_write_we", 64'(obs_we), 64'd1);
        cmp("t2_dm_done_first", 64'(obs_done_dm), 64'd1);
        do_txn(1'b0, 1'b0, 1'b0, '0, '0, '0, 0, 1'b0, 1'b0, '0);
        cmp("t2_if_done_second", 64'(obs_done_if), 64'd1);

        // load with 5 extra wait cycles
        do_txn(1'b0, 1'b1, 1'b0, '0, 32'h100, '0, 5, 1'b0, 1'b0, '0);
        cmp("t3_busy_cycles", 64'(obs_busy), 64'd8);
        cmp("t3_dm_done", 64'(obs_done_dm), 64'd1);

        // mem_ready stuck low -> timeout
        do_txn(1'b0, 1'b1, 1'b0, '0, 32'h200, '0, 500, 1'b0, 1'b0, '0);
        cmp("t4_busy_cycles", 64'(obs_busy), 64'd64);
        cmp("t4_err_timeout", 64'(err_timeout), 64'd1);
        cmp("t4_dm_done", 64'(obs_done_dm), 64'd1);

        // read/write conflict
        do_txn(1'b0, 1'b1, 1'b1, '0, 32'h300, 32'hA5A5, 1, 1'b0, 1'b0, '0);
        cmp("t5_write_we", 64'(obs_we), 64'd1);
        cmp("t5_err_conflict", 64'(err_conflict), 64'd1);

        // reset in cycle 2 of a load
        dm_rd = 1'b1; dm_addr = 32'h400; mem_ready = 1'b0;
        step();
        step();
        #2;
        rst = 1'b1; dm_rd = 1'b0;
        exp_if_rdata = '0; exp_dm_rdata = '0; exp_err_c = 1'b0; exp_err_t = 1'b0;
        #1;
        check_outs(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        cmp("t6_mem_addr", 64'(mem_addr), 64'd0);
        step();
        check_outs(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check_outs(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        do_txn(1'b0, 1'b1, 1'b0, '0, 32'h404, '0, 0, 1'b0, 1'b1, 32'h1234_5678);
        cmp("t6_dm_rdata", 64'(dm_rdata), 64'h1234_5678);

        // randomized accesses
        for (int i = 0; i < 40; i++) begin
            rq = 3'($urandom_range(0, 7));
            do_txn(rq[0], rq[1] & ($urandom_range(0, 3) != 0), rq[2] & ($urandom_range(0, 3) == 0),
                   $urandom, $urandom, $urandom, int'($urandom_range(0, 6)),
                   ($urandom_range(0, 4) == 0), 1'b0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
